// File: rtl/bcd_stopwatch_counter.sv
// Four-digit BCD stopwatch: prescaled count ticks, start/stop, lap freeze and clear.
// q carries the ones digit in the top nibble down to thousands in the bottom nibble.
module bcd_stopwatch_counter #(
    parameter int TICK_DIV = 5000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] q,
    output logic        running,
    output logic        wrap
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [3:0]    ones, tens, hundreds, thousands;
    logic [3:0]    ones_n, tens_n, hundreds_n, thousands_n;
    logic [15:0]   live;
    logic [15:0]   snapshot;
    logic          start_stop_d, lap_d;
    logic          ss_edge, lap_edge, active, tick, all_nines;

    assign ss_edge   = start_stop & ~start_stop_d;
    assign lap_edge  = lap & ~lap_d;
    assign active    = (state == RUN) || (state == LAP);
    assign tick      = active && (prescaler == PMAX);
    assign all_nines = (ones == 4'd9) && (tens == 4'd9) &&
                       (hundreds == 4'd9) && (thousands == 4'd9);
    assign live      = {ones, tens, hundreds, thousands};

    assign q       = (state == LAP) ? snapshot : live;
    assign running = active;

    // Ripple-carry BCD increment; digits only ever step from 0..9, so 10-15 never appear.
    always_comb begin
        ones_n      = ones;
        tens_n      = tens;
        hundreds_n  = hundreds;
        thousands_n = thousands;
        if (ones != 4'd9) begin
            ones_n = ones + 4'd1;
        end else begin
            ones_n = 4'd0;
            if (tens != 4'd9) begin
                tens_n = tens + 4'd1;
            end else begin
                tens_n = 4'd0;
                if (hundreds != 4'd9) begin
                    hundreds_n = hundreds + 4'd1;
                end else begin
                    hundreds_n  = 4'd0;
                    thousands_n = (thousands == 4'd9) ? 4'd0 : thousands + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            prescaler    <= '0;
            ones         <= 4'd0;
            tens         <= 4'd0;
            hundreds     <= 4'd0;
            thousands    <= 4'd0;
            snapshot     <= 16'h0000;
            start_stop_d <= 1'b0;
            lap_d        <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            start_stop_d <= start_stop;
            lap_d        <= lap;
            if (clear) begin
                state     <= IDLE;
                prescaler <= '0;
                ones      <= 4'd0;
                tens      <= 4'd0;
                hundreds  <= 4'd0;
                thousands <= 4'd0;
                snapshot  <= 16'h0000;
                wrap      <= 1'b0;
            end else begin
                // Counting uses the state before any transition taken on this edge.
                if (active) begin
                    prescaler <= tick ? '0 : prescaler + 1'b1;
                end
                wrap <= tick && all_nines;
                if (tick) begin
                    ones      <= ones_n;
                    tens      <= tens_n;
                    hundreds  <= hundreds_n;
                    thousands <= thousands_n;
                end

                // start_stop outranks lap when both edges land together.
                case (state)
                    IDLE: begin
                        if (ss_edge) state <= RUN;
                    end
                    RUN: begin
                        if (ss_edge) begin
                            state <= STOP;
                        end else if (lap_edge) begin
                            state    <= LAP;
                            snapshot <= live;
                        end
                    end
                    LAP: begin
                        if (ss_edge)       state <= STOP;
                        else if (lap_edge) state <= RUN;
                    end
                    STOP: begin
                        if (ss_edge) state <= RUN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
